// File: rtl/sr_capture_pkg.sv
// Shared types and constants for the shift-register frame capture block.
package sr_capture_pkg;

  // Frame hunter states: looking for sync, or counting payload shifts
  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Width of the captured-frame counter (wraps at all-ones)
  localparam int FRAME_CNT_W = 16;

  // Default sync pattern expected in the low byte of the shift register
  localparam logic [7:0] SYNC_PAT_DEFAULT = 8'hA5;

endpackage

// File: rtl/sr_parity_chk.sv
// Even-parity checker for a captured payload.
// The checker is only needed, and only defined, when
// SR_FRAME_CAPTURE_PARITY_EN is defined.
// 'odd' is a combinational XOR reduction of the payload, used to veto a capture.
// 'err' is a sticky flag set by a failing check and cleared by 'clr'.
`ifdef SR_FRAME_CAPTURE_PARITY_EN
module sr_parity_chk #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data,
  input  logic         check,
  input  logic         clr,
  output logic         odd,
  output logic         err
);

  logic err_q;
  logic err_d;

  assign odd = ^data;

  // Sticky error: set on a failing check, clear wins over set
  always_comb begin
    err_d = err_q;
    if (check && odd) begin
      err_d = 1'b1;
    end
    if (clr) begin
      err_d = 1'b0;
    end
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule
`endif

// File: rtl/sr_frame_capture.sv
// Frame capture stage downstream of a serial-in/parallel-out shift register.
// Hunts for a sync pattern in the low bits of the parallel word, counts the
// payload shifts that follow, then latches the payload into a single-entry
// valid/ready output register.
// Optional feature macro: SR_FRAME_CAPTURE_PARITY_EN
//   defined   -> payload MSB is an even-parity bit; odd frames are dropped
//                and flagged on the sticky parity_err output.
//   undefined -> no parity check, parity_err tied low.
module sr_frame_capture
  import sr_capture_pkg::*;
#(
  parameter int                NDATA     = 128,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_W'(SYNC_PAT_DEFAULT),
  parameter int                PAYLOAD_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_ena_n,
  input  logic [NDATA-1:0]       sr_data,
  input  logic                   flush,
  input  logic                   word_ready,
  output logic                   word_valid,
  output logic [PAYLOAD_W-1:0]   word_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   ovf,
  output logic                   parity_err
);

  // Payload plus sync must fit inside the shift register
  if (PAYLOAD_W + SYNC_W > NDATA) begin : g_param_check
    $error("sr_frame_capture: PAYLOAD_W + SYNC_W must not exceed NDATA");
  end

  localparam int CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;

  // Shift-register bits above the payload carry the already-consumed sync
  // and older history; they are intentionally not looked at.
  logic unused_sr_hi;
  assign unused_sr_hi = ^sr_data[NDATA-1:PAYLOAD_W];

  logic                   shift_seen_q, shift_seen_d;
  state_t                 state_q,      state_d;
  logic [CNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
  logic                   word_valid_q, word_valid_d;
  logic [PAYLOAD_W-1:0]   word_data_q,  word_data_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
  logic                   ovf_q,        ovf_d;

  logic [PAYLOAD_W-1:0]   payload;
  logic                   sync_hit;
  logic                   last_bit;
  logic                   capture;
  logic                   par_odd;
  logic                   accept;

  assign payload  = sr_data[PAYLOAD_W-1:0];
  assign sync_hit = (sr_data[SYNC_W-1:0] == SYNC_PAT);
  assign last_bit = (bit_cnt_q == CNT_W'(PAYLOAD_W - 1));

  // sr_data reflects a shift one cycle after the strobe, so every decision
  // is qualified by the registered strobe rather than the raw one.
  assign capture  = shift_seen_q && (state_q == COLLECT) && last_bit;

`ifdef SR_FRAME_CAPTURE_PARITY_EN
  sr_parity_chk #(
    .W (PAYLOAD_W)
  ) u_parity_chk (
    .clk   (clk),
    .rst   (rst),
    .data  (payload),
    .check (capture),
    .clr   (flush),
    .odd   (par_odd),
    .err   (parity_err)
  );
`else
  assign par_odd    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // A parity-failing frame never reaches the output register, so it can
  // neither be delivered nor count as an overflow.
  assign accept = capture && !par_odd;

  // Next-state logic: frame hunter, output handshake, flush override
  always_comb begin
    shift_seen_d = !shift_ena_n;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    frame_cnt_d  = frame_cnt_q;
    ovf_d        = ovf_q;

    if (shift_seen_q) begin
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            state_d   = COLLECT;
            bit_cnt_d = '0;
          end
        end
        COLLECT: begin
          // Sync patterns inside the payload are ignored until capture
          if (last_bit) begin
            state_d   = HUNT;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = HUNT;
          bit_cnt_d = '0;
        end
      endcase
    end

    // Downstream takes the held word
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    // Room is judged on the pre-handshake valid, so a capture may refill
    // the register in the same cycle the old word leaves.
    if (accept) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = payload;
        word_valid_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Flush aborts everything except the frame count and the last data
    if (flush) begin
      state_d      = HUNT;
      bit_cnt_d    = '0;
      word_valid_d = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_seen_q <= 1'b0;
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      shift_seen_q <= shift_seen_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign frame_cnt  = frame_cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_sr_frame_capture.sv
// Testbench for sr_frame_capture driven through a 128-bit MSB-first
// serial-in/parallel-out shift register. Outputs are compared every cycle
// with a frame-level reference model, plus explicit checks per scenario.
module tb_sr_frame_capture;

  localparam logic [63:0] P1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P2   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] PODD = 64'h0123_4567_89AB_CDEE;

`ifdef SR_FRAME_CAPTURE_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         shift_ena_n = 1'b1;
  logic         din = 1'b0;
  logic         flush = 1'b0;
  logic         word_ready = 1'b0;
  logic [127:0] sr_data;
  logic         word_valid;
  logic [63:0]  word_data;
  logic [15:0]  frame_cnt;
  logic         ovf;
  logic         parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Upstream shift register, newest bit enters at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_data <= '0;
    else if (!shift_ena_n) sr_data <= {sr_data[126:0], din};
  end

  sr_frame_capture dut (
    .clk         (clk),
    .rst         (rst),
    .shift_ena_n (shift_ena_n),
    .sr_data     (sr_data),
    .flush       (flush),
    .word_ready  (word_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .frame_cnt   (frame_cnt),
    .ovf         (ovf),
    .parity_err  (parity_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] m_hist;     // every bit shifted so far, newest at bit 0
  bit           m_pend;     // a shift happened at the previous edge, not yet judged
  bit           m_hunt;
  int           m_pl_seen;  // payload shifts seen since sync
  bit           m_valid;
  logic [63:0]  m_data;
  logic [15:0]  m_frames;
  bit           m_ovf;
  bit           m_perr;

  task automatic model_reset();
    m_hist = '0; m_pend = 0; m_hunt = 1; m_pl_seen = 0;
    m_valid = 0; m_data = '0; m_frames = '0; m_ovf = 0; m_perr = 0;
  endtask

  task automatic model_edge(input bit sh, input bit b, input bit fl, input bit rdy);
    bit          cap;
    bit          was_valid;
    logic [63:0] pl;
    cap = 0;
    pl  = m_hist[63:0];
    if (m_pend) begin
      if (m_hunt) begin
        if (m_hist[7:0] == 8'hA5) begin
          m_hunt = 0;
          m_pl_seen = 0;
        end
      end else begin
        m_pl_seen++;
        if (m_pl_seen == 64) begin
          cap = 1;
          m_hunt = 1;
        end
      end
    end
    was_valid = m_valid;
    if (was_valid && rdy) m_valid = 0;
    if (cap) begin
      if (PAR_ON && (^pl)) m_perr = 1;
      else if (!was_valid || rdy) begin
        m_data = pl; m_valid = 1; m_frames = m_frames + 16'd1;
      end else m_ovf = 1;
    end
    if (fl) begin
      m_hunt = 1; m_pl_seen = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
    end
    if (sh) m_hist = {m_hist[126:0], b};
    m_pend = sh;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit sh, input bit b, input bit fl, input bit rdy);
    shift_ena_n = !sh; din = b; flush = fl; word_ready = rdy;
    @(posedge clk);
    model_edge(sh, b, fl, rdy);
    #1;
    chk("valid", word_valid, m_valid);
    chk("data", word_data, m_data);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("ovf", ovf, m_ovf);
    chk("parity_err", parity_err, m_perr);
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n, input bit rdy);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, rdy);
  endtask

  task automatic shift_frame(input logic [63:0] p, input bit rdy);
    shift_bits(64'hA5, 8, rdy);
    shift_bits(p, 64, rdy);
  endtask

  task automatic apply_reset();
    rst = 1'b1; shift_ena_n = 1'b1; din = 1'b0; flush = 1'b0; word_ready = 1'b0;
    #2;
    model_reset();
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_data", word_data, 64'h0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    #1 rst = 1'b0;
  endtask

  task automatic rstep(input bit sh, input bit b);
    step(sh, b, $urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0);
  endtask

  // True if some window while shifting A5 after {000,r} already equals A5
  function automatic bit early_sync(input logic [4:0] r);
    logic [15:0] s;
    logic [15:0] w;
    s = {3'b000, r, 8'hA5};
    for (int k = 0; k < 8; k++) begin
      w = s >> (8 - k);
      if (w[7:0] == 8'hA5) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [4:0]  r5;
    logic [63:0] p5;

    apply_reset();

    // Scenario 1: single frame, ready high, two-edge latency
    shift_frame(P1, 1'b1);
    chk("t1_before_capture", word_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", word_valid, 1'b1);
    chk("t1_data", word_data, P1);
    chk("t1_frame_cnt", frame_cnt, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_drained", word_valid, 1'b0);

    // Scenario 2: back-to-back frames with ready low -> overflow
    apply_reset();
    shift_frame(P1, 1'b0);
    shift_frame(P2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_valid", word_valid, 1'b1);
    chk("t2_data", word_data, P1);
    chk("t2_ovf", ovf, 1'b1);
    chk("t2_frame_cnt", frame_cnt, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_after_xfer", word_valid, 1'b0);

    // Scenario 3: second capture coincides with transfer of the first
    apply_reset();
    shift_frame(P1, 1'b0);
    shift_frame(P2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_valid", word_valid, 1'b1);
    chk("t3_data", word_data, P2);
    chk("t3_ovf", ovf, 1'b0);
    chk("t3_frame_cnt", frame_cnt, 16'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Scenario 4a: partial frame aborted by flush
    apply_reset();
    shift_bits(64'hA5, 8, 1'b1);
    shift_bits(64'h0, 30, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    shift_frame(P1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4f_valid", word_valid, 1'b1);
    chk("t4f_data", word_data, P1);
    chk("t4f_frame_cnt", frame_cnt, 16'd1);

    // Scenario 4b: partial frame aborted by reset
    apply_reset();
    shift_bits(64'hA5, 8, 1'b1);
    shift_bits(64'h0, 30, 1'b1);
    apply_reset();
    shift_frame(P1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4r_valid", word_valid, 1'b1);
    chk("t4r_data", word_data, P1);
    chk("t4r_frame_cnt", frame_cnt, 16'd1);

    // Scenario 5: noise before sync, payload containing A5
    apply_reset();
    r5 = 5'($urandom);
    while (early_sync(r5)) r5 = 5'($urandom);
    p5 = {$urandom, $urandom};
    p5[39:32] = 8'hA5;
    p5[15:8]  = 8'hA5;
    p5[63]    = ^p5[62:0];
    shift_bits({59'h0, r5}, 5, 1'b1);
    chk("t5_noise_no_valid", word_valid, 1'b0);
    shift_frame(p5, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_valid", word_valid, 1'b1);
    chk("t5_data", word_data, p5);
    chk("t5_frame_cnt", frame_cnt, 16'd1);

    // Scenario 6: odd-parity payload
    apply_reset();
    shift_frame(PODD, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (PAR_ON) begin
      chk("t6_valid", word_valid, 1'b0);
      chk("t6_parity_err", parity_err, 1'b1);
      chk("t6_frame_cnt", frame_cnt, 16'd0);
      chk("t6_ovf", ovf, 1'b0);
    end else begin
      chk("t6_valid", word_valid, 1'b1);
      chk("t6_data", word_data, PODD);
      chk("t6_parity_err", parity_err, 1'b0);
      chk("t6_frame_cnt", frame_cnt, 16'd1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_flush_clears", parity_err, 1'b0);

    // Randomised frames with gaps, noise shifts, random ready and flush
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      logic [63:0] p;
      logic [71:0] fr;
      int          gap;
      gap = $urandom_range(0, 6);
      p   = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) p[63] = ^p[62:0];
      fr  = {8'hA5, p};
      for (int g = 0; g < gap; g++) rstep($urandom_range(0, 2) == 0, 1'($urandom));
      for (int i = 71; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) rstep(1'b0, 1'b0);
        rstep(1'b1, fr[i]);
      end
      if (f == 20) apply_reset();
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
